// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) constants and state encoding for the Reed-Solomon datapath.
// The default field is GF(32) generated by x^5 + x^2 + 1.
package rs_gf_pkg;

  localparam int              M_DEF    = 5;
  localparam logic [M_DEF-1:0] POLY_DEF = 5'b00101;
  localparam int              NCH_DEF  = 4;

  localparam logic [M_DEF-1:0] ALPHA = 5'd2;
  // alpha^1 .. alpha^NCH_DEF, the syndrome evaluation points
  localparam logic [M_DEF-1:0] ALPHA_POW [NCH_DEF] = '{5'd2, 5'd4, 5'd8, 5'd16};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gf_horner_bank_if.sv
// Symbol stream and result bus between a block source and the Horner bank.
interface gf_horner_bank_if
  import rs_gf_pkg::*;
#(
  parameter int M   = M_DEF,
  parameter int NCH = NCH_DEF
);
  logic               start;
  logic [NCH*M-1:0]   coef;
  logic               in_valid;
  logic [M-1:0]       in_sym;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [NCH*M-1:0]   result;

  modport master (
    output start, coef, in_valid, in_sym,
    input  in_ready, busy, done, result
  );

  modport slave (
    input  start, coef, in_valid, in_sym,
    output in_ready, busy, done, result
  );
endinterface

// File: rtl/gf_mult.sv
// Combinational polynomial-basis GF(2^M) multiplier, reduced modulo x^M + POLY.
module gf_mult #(
  parameter int           M    = 5,
  parameter logic [M-1:0] POLY = 5'b00101
) (
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_p
);
  logic [M-1:0] w_t;

  // Shift-and-add: w_t walks through a*x^k, reduced at every step.
  always_comb begin
    o_p = '0;
    w_t = i_a;
    for (int k = 0; k < M; k++) begin
      if (i_b[k]) o_p = o_p ^ w_t;
      w_t = w_t[M-1] ? ({w_t[M-2:0], 1'b0} ^ POLY) : {w_t[M-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/gf_horner_bank.sv
// NCH-channel GF(2^M) Horner evaluator: acc_i <= acc_i*coef_i + sym over LEN symbols,
// publishing all channels at once with a one-cycle done pulse.
module gf_horner_bank
  import rs_gf_pkg::*;
#(
  parameter int           M    = M_DEF,
  parameter logic [M-1:0] POLY = POLY_DEF,
  parameter int           NCH  = NCH_DEF,
  parameter int           LEN  = 31
) (
  input  logic            clock,
  input  logic            reset,
  gf_horner_bank_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [M-1:0]     r_acc  [NCH];
  logic [M-1:0]     r_coef [NCH];
  logic [NCH*M-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic [M-1:0]     w_prod [NCH];
  logic [M-1:0]     w_step [NCH];
  logic             w_accept;
  logic             w_last;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      gf_mult #(.M(M), .POLY(POLY)) u_mult (
        .i_a (r_acc[gi]),
        .i_b (r_coef[gi]),
        .o_p (w_prod[gi])
      );
      assign w_step[gi] = w_prod[gi] ^ bus.in_sym;
    end
  endgenerate

  assign w_accept = bus.in_valid && (r_state == RUN);
  assign w_last   = w_accept && (r_count == CW'(LEN - 1));

  // start takes priority over the symbol step, so a start on the last
  // symbol aborts that block without touching result or raising done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_acc[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_state <= RUN;
        r_count <= '0;
        r_busy  <= 1'b1;
        for (int i = 0; i < NCH; i++) begin
          r_acc[i]  <= '0;
          r_coef[i] <= bus.coef[i*M +: M];
        end
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
        for (int i = 0; i < NCH; i++) r_acc[i] <= w_step[i];
        if (w_last) begin
          for (int i = 0; i < NCH; i++) r_result[i*M +: M] <= w_step[i];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.in_ready = r_busy;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
endmodule

// File: tb/tb_gf_horner_bank.sv
// Scoreboard bench for gf_horner_bank: expected result words are queued when a
// block is driven and compared when done is seen.
module tb_gf_horner_bank;
  import rs_gf_pkg::*;

  localparam int M   = 5;
  localparam int NCH = 4;
  localparam int LEN = 31;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gf_horner_bank_if #(.M(M), .NCH(NCH)) bus ();

  gf_horner_bank #(.M(M), .POLY(5'b00101), .NCH(NCH), .LEN(LEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [NCH*M-1:0] exp_q[$];
  logic [M-1:0]     syms[LEN];

  // Full carry-less product, then long division by x^5+x^2+1.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    logic [2*M-2:0] g;
    p = '0;
    g = (2*M-1)'(6'b100101);
    for (int k = 0; k < M; k++)
      if (b[k]) p = p ^ ((2*M-1)'(a) << k);
    for (int k = 2*M-2; k >= M; k--)
      if (p[k]) p = p ^ (g << (k - M));
    return p[M-1:0];
  endfunction

  function automatic logic [NCH*M-1:0] ref_block(input logic [NCH*M-1:0] c);
    logic [NCH*M-1:0] r;
    logic [M-1:0] acc;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      acc = '0;
      for (int k = 0; k < LEN; k++) acc = ref_mul(acc, c[i*M +: M]) ^ syms[k];
      r[i*M +: M] = acc;
    end
    return r;
  endfunction

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && bus.done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: result=%h, required no done pulse", bus.result);
      end else begin
        logic [NCH*M-1:0] e;
        e = exp_q.pop_front();
        if (bus.result !== e) begin
          fails++;
          $display("FAIL done_result: got %h, expected %h", bus.result, e);
        end else begin
          $display("[TB] done result=%h ok", bus.result);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [NCH*M-1:0] c);
    bus.start = 1'b1;
    bus.coef  = c;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [M-1:0] s, input int gap);
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_sym   = s;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({bus.result, bus.busy, bus.done, bus.in_ready} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h/%b/%b/%b, expected all 0",
               bus.result, bus.busy, bus.done, bus.in_ready);
    end
    reset = 1'b0;
    do_start((NCH*M)'($urandom));
    for (int k = 0; k < 5; k++) send(M'($urandom), 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if ({bus.result, bus.busy, bus.done, bus.in_ready} !== '0) begin
      fails++;
      $display("FAIL reset_mid_block: got %h/%b/%b/%b, expected all 0",
               bus.result, bus.busy, bus.done, bus.in_ready);
    end
    for (int k = 0; k < 3; k++) send(5'h1F, 1);
    tick();
    tests++;
    if (bus.result !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid_ignored: result=%h busy=%b, expected 0/0", bus.result, bus.busy);
    end
    $display("[TB] reset test done");
  endtask

  task automatic test_all_ones();
    logic [NCH*M-1:0] c;
    c = {NCH{5'd1}};
    for (int k = 0; k < LEN; k++) syms[k] = 5'h1F;
    exp_q.push_back(ref_block(c));
    do_start(c);
    for (int k = 0; k < LEN - 1; k++) send(syms[k], 0);
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL ones_early_done: done=%b, expected 0", bus.done);
    end
    send(syms[LEN-1], 0);
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL ones_latency: done=%b busy=%b, expected 1/0", bus.done, bus.busy);
    end
    for (int i = 0; i < NCH; i++) begin
      tests++;
      if (bus.result[i*M +: M] !== 5'h1F) begin
        fails++;
        $display("FAIL ones_ch%0d: got %h, expected 1f", i, bus.result[i*M +: M]);
      end
    end
    tick();
  endtask

  task automatic test_impulse(input bit gaps);
    logic [NCH*M-1:0] c;
    int busy_bad;
    c = {5'd16, 5'd8, 5'd4, 5'd2};
    busy_bad = 0;
    for (int k = 0; k < LEN; k++) syms[k] = (k == 0) ? 5'd1 : 5'd0;
    exp_q.push_back(ref_block(c));
    do_start(c);
    for (int k = 0; k < LEN; k++) begin
      send(syms[k], gaps ? int'($urandom_range(0, 5)) : 0);
      if (k < LEN - 1 && bus.busy !== 1'b1) busy_bad++;
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL impulse_busy: busy dropped %0d times, expected 0", busy_bad);
    end
    tests++;
    if (bus.done !== 1'b1 || bus.result[4:0] !== 5'h12 || bus.result[9:5] !== 5'h09) begin
      fails++;
      $display("FAIL impulse_syndrome: done=%b r0=%h r1=%h, expected 1/12/09",
               bus.done, bus.result[4:0], bus.result[9:5]);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [NCH*M-1:0] c;
    c = {5'd16, 5'd8, 5'd4, 5'd2};
    for (int k = 0; k < LEN; k++) syms[k] = (k == LEN - 1) ? 5'd1 : 5'd0;
    exp_q.push_back(ref_block(c));
    do_start(c);
    for (int k = 0; k < LEN; k++) send(syms[k], 0);
    tests++;
    if (bus.result !== {NCH{5'h01}}) begin
      fails++;
      $display("FAIL impulse_end: got %h, expected all 01", bus.result);
    end
    tick();
    do_start((NCH*M)'($urandom));
    for (int k = 0; k < 10; k++) send(M'($urandom), 0);
    c = (NCH*M)'($urandom);
    for (int k = 0; k < LEN; k++) syms[k] = M'($urandom);
    exp_q.push_back(ref_block(c));
    do_start(c);
    for (int k = 0; k < LEN - 1; k++) send(syms[k], 0);
    tests++;
    if (bus.result !== {NCH{5'h01}} || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_hold: result=%h busy=%b, expected all 01 / 1", bus.result, bus.busy);
    end
    send(syms[LEN-1], 0);
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart_done: done=%b, expected 1", bus.done);
    end
    tick();
  endtask

  task automatic test_boundary_start();
    logic [NCH*M-1:0] prev;
    do_start((NCH*M)'($urandom));
    for (int k = 0; k < LEN - 1; k++) send(M'($urandom), 0);
    prev = bus.result;
    bus.start    = 1'b1;
    bus.coef     = (NCH*M)'($urandom);
    bus.in_valid = 1'b1;
    bus.in_sym   = M'($urandom);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.result !== prev) begin
      fails++;
      $display("FAIL boundary_start: done=%b busy=%b result=%h, expected 0/1/%h",
               bus.done, bus.busy, bus.result, prev);
    end
    for (int k = 0; k < LEN; k++) syms[k] = 5'd0;
    exp_q.push_back(ref_block(bus.coef));
    for (int k = 0; k < LEN - 1; k++) send(syms[k], 0);
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL boundary_count: done=%b busy=%b after %0d symbols, expected 0/1",
               bus.done, bus.busy, LEN - 1);
    end
    send(syms[LEN-1], 0);
    tests++;
    if (bus.done !== 1'b1 || bus.result !== '0) begin
      fails++;
      $display("FAIL boundary_zero_block: done=%b result=%h, expected 1/0", bus.done, bus.result);
    end
    tick();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.coef     = '0;
    bus.in_valid = 1'b0;
    bus.in_sym   = '0;
    #1;
    test_reset();
    test_all_ones();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_abort();
    test_boundary_start();
    repeat (3) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_results: %0d blocks never completed, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gf_horner_bank.md
Name: gf_horner_bank

Overview:
- Parametrised GF(2^M) multiply-accumulate register bank with NCH parallel channels.
- Each accepted input symbol updates every channel by the Horner step acc_i <= acc_i*coef_i + sym.
- A block is LEN symbols long. Completion is signalled with a done pulse and results are held stable.
- Generalises the fixed 5-bit adder, multiplier and load/hold register into one sequential unit. It serves as the syndrome engine (coef_i = alpha^(i+1)) and as a generic polynomial evaluator in the RS decoder.

Parameters:
- M, 5, symbol width in bits (field GF(2^M)).
- POLY, 5'b00101, low M bits of the primitive polynomial; the default is x^5+x^2+1.
- NCH, 4, number of parallel accumulator channels.
- LEN, 31, symbols per block (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new block; latches coef and clears the accumulators.
- coef  input  NCH*M  per-channel multiplier; channel i occupies bits [i*M +: M]; sampled only when start is accepted.
- in_valid  input  1  in_sym is valid this cycle.
- in_sym  input  M  received symbol; first symbol is the highest-order coefficient.
- in_ready  output  1  high while busy; a symbol is accepted when in_valid && in_ready.
- busy  output  1  block in progress.
- done  output  1  one-cycle pulse when results update.
- result  output  NCH*M  final accumulator values, channel i at [i*M +: M]; held until the next done.

Behaviour:
- Reset (synchronous, highest priority): acc, coef_q, result and count = 0; busy = 0; done = 0; state IDLE.
- States: IDLE, RUN.
- IDLE -> RUN on start. In that cycle: coef_q <= coef, acc <= 0, count <= 0, busy <= 1. done is 0.
- RUN, accept cycle (in_valid = 1):
  - for every i, acc_i <= gfmul(acc_i, coef_q_i) XOR in_sym;
  - count <= count + 1.
- RUN, cycle with in_valid = 0: acc and count hold. Gaps of any length are allowed.
- RUN, accept cycle with count == LEN-1: this is the last symbol.
  - result_i <= gfmul(acc_i, coef_q_i) XOR in_sym;
  - done <= 1 for exactly the next cycle;
  - busy <= 0 and state <= IDLE.
- Latency: result and done become valid one cycle after the LEN-th accept.
- start while in RUN (including on the last-symbol cycle): start wins. The block restarts as IDLE->RUN does, no done is issued for the aborted block, and result is unchanged.
- start in the same cycle a done pulse is visible: legal; the new block begins.
- in_valid while busy = 0: ignored, no state change.
- Arithmetic:
  - addition is bitwise XOR;
  - gfmul is polynomial-basis multiplication reduced modulo x^M + POLY;
  - fully combinational, no pipeline inside the step.
- Width rules:
  - count width is clog2(LEN+1);
  - result must never expose partial accumulators.
- Reset asserted mid-block: the block is aborted, all outputs return to reset values the next cycle, and there is no done.

Decomposition:
- Package rs_gf_pkg holds:
  - the default M and POLY;
  - field constants: ALPHA = 'd2 and the alpha^1..alpha^NCH table for syndrome use;
  - the state encoding (IDLE/RUN).
- Sub-module gf_mult: combinational generic GF(2^M) multiplier, parametrised by M and POLY, instantiated NCH times.
- The Horner adder is inline XOR; no separate module.

Test Plan:
- Reset: assert reset 2 cycles mid-traffic -> result = 0, busy = 0, done = 0, in_ready = 0; in_valid pulses while idle leave result at 0.
- All-ones coefficient: coef = {1,1,1,1}, start, then 31 symbols of 5'h1F back-to-back -> done exactly 1 cycle after the 31st accept, every result_i = 5'h1F.
- Syndrome impulse:
  - stimulus: coef = {16,8,4,2}, start, in_sym = 1 then 30 zeros;
  - required response: result_0 = alpha^30 = 5'h12 and result_1 = alpha^29 = 5'h09.
- Same stimulus with random in_valid gaps of 0-5 cycles -> identical result values; done delayed correspondingly; busy stays high throughout.
- Impulse at end (30 zeros then in_sym = 1) -> all result_i = 5'h01. Then start a second block and re-assert start after 10 symbols -> no done for the aborted block, result stays 5'h01 until the restarted block completes.
- Boundary start: assert start on the cycle of the 31st accept -> new block begins, no done pulse, count restarts at 0. Next block of all-zero symbols -> done, result = 0.
